// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generator, in-order fetch FIFO and redirect/drop handling.
// Optional build define IFU_MISALIGN_EN halts fetching on a misaligned redirect target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        fetch_misalign
);
  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        fifo_data_q [DEPTH];
  logic [31:0]        fifo_pc_q   [DEPTH];

  logic [31:0]        redir_tgt;
  logic               redir_bad;
  logic               req_fire;
  logic               rsp_take;
  logic               push;
  logic               pop;

`ifdef IFU_MISALIGN_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign redir_bad = 1'b0;
`endif

  // Credit check counts both in-flight and buffered words so a response always has a slot.
  assign imem_req_valid = rst_n && (state_q == S_FETCH) && !redirect_valid &&
                          (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  // Responses with nothing outstanding belong to a stream killed by reset.
  assign rsp_take       = imem_rsp_valid && (outst_q != '0);
  assign push           = rsp_take && (drop_q == '0) && !redirect_valid;

  assign instr_valid    = (count_q != '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready;
  assign instruction    = (count_q != '0) ? fifo_data_q[head_q] : '0;
  assign instr_pc       = (count_q != '0) ? fifo_pc_q[head_q] : '0;
  assign fetch_misalign = misalign_q;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    state_d    = state_q;
    misalign_d = misalign_q;

    if (req_fire) pc_d = pc_q + 32'd4;
    outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
    if (rsp_take) begin
      if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
      else              rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (push) tail_d = tail_q + PTR_W'(1);
    if (pop)  head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Every word still in flight after this edge belongs to the old stream.
    if (redirect_valid) begin
      pc_d       = redir_tgt;
      rsp_pc_d   = redir_tgt;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outst_q - CNT_W'(rsp_take);
      state_d    = redir_bad ? S_HALT : S_FETCH;
      misalign_d = redir_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[tail_q] <= imem_rsp_data;
      fifo_pc_q[tail_q]   <= rsp_pc_q;
    end
  end

endmodule
